// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
//   General-purpose register file for the ID stage with two registered read
//   ports, one write port and a handshaked dump sequencer that streams every
//   register (one per transfer) towards the UART debug path.
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   read_addr_a    read port A address
//   read_addr_b    read port B address
//   write_address  write address
//   write_data     write data
//   reg_write      1 = write this cycle
//   data_a         registered read data A (1-cycle latency)
//   data_b         registered read data B (1-cycle latency)
//   dump_start     request a full dump (sampled in IDLE only)
//   dump_busy      high from accepting dump_start until dump_done
//   dump_valid     dump_index/dump_data hold a valid element
//   dump_ready     consumer accepts the current element
//   dump_index     index of the current element
//   dump_data      value of the current element
//   dump_done      one-cycle pulse after the last element is accepted
// -----------------------------------------------------------------------------
module regfile_dump #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter bit ZERO_REG    = 1'b1,
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic                  dump_start,
    output logic                  dump_busy,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_index,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] rd_a_s;
    logic [DATA_WIDTH-1:0] rd_b_s;
    logic [DATA_WIDTH-1:0] dump_val_s;
    logic [ADDR_WIDTH-1:0] dump_idx_nxt_s;
    logic                  load_s;
    logic [ADDR_WIDTH-1:0] dump_index_r;
    logic [DATA_WIDTH-1:0] dump_data_r;
    logic [DATA_WIDTH-1:0] data_a_r;
    logic [DATA_WIDTH-1:0] data_b_r;
    logic                  dump_valid_r;
    logic                  dump_busy_r;
    logic                  dump_done_r;

    // Value a read of addr sees at this edge: zero register first, then the
    // optional bypass of the write in flight, otherwise the stored contents.
    function automatic logic [DATA_WIDTH-1:0] rd_sel(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  wf
    );
        logic [DATA_WIDTH-1:0] v;
        if (ZERO_REG && (addr == '0)) begin
            v = '0;
        end else if (wf && reg_write && (write_address == addr)) begin
            v = write_data;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Write enable with the zero-register drop applied.
    always_comb begin
        wr_en_s = 1'b0;
        if (reg_write && !(ZERO_REG && (write_address == '0))) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Read-port values; forwarding follows WRITE_FIRST.
    always_comb begin
        rd_a_s = rd_sel(read_addr_a, regs_r[read_addr_a], WRITE_FIRST);
        rd_b_s = rd_sel(read_addr_b, regs_r[read_addr_b], WRITE_FIRST);
    end

    // Dump FSM next state and element-load decision.
    always_comb begin
        state_nxt_s    = state_r;
        load_s         = 1'b0;
        dump_idx_nxt_s = dump_index_r;
        case (state_r)
            IDLE: begin
                if (dump_start) begin
                    state_nxt_s    = SEND;
                    load_s         = 1'b1;
                    dump_idx_nxt_s = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (dump_index_r == LAST_IDX) begin
                        state_nxt_s = DONE;
                    end else begin
                        load_s         = 1'b1;
                        dump_idx_nxt_s = dump_index_r + ADDR_WIDTH'(1);
                    end
                end else begin
                    state_nxt_s = SEND;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // The dump always sees a write landing on the same edge as the load,
    // independent of WRITE_FIRST, so the element never lags the register.
    always_comb begin
        dump_val_s = rd_sel(dump_idx_nxt_s, regs_r[dump_idx_nxt_s], 1'b1);
    end

    // Register array storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_r[write_address] <= write_data;
        end
    end

    // Registered read ports, updated every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_a_r <= '0;
            data_b_r <= '0;
        end else begin
            data_a_r <= rd_a_s;
            data_b_r <= rd_b_s;
        end
    end

    // Dump FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Current dump element; held while the consumer stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dump_index_r <= '0;
            dump_data_r  <= '0;
        end else if (load_s) begin
            dump_index_r <= dump_idx_nxt_s;
            dump_data_r  <= dump_val_s;
        end
    end

    // Handshake flags registered from the next state so they align with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dump_valid_r <= 1'b0;
            dump_busy_r  <= 1'b0;
            dump_done_r  <= 1'b0;
        end else begin
            dump_valid_r <= (state_nxt_s == SEND);
            dump_busy_r  <= (state_nxt_s != IDLE);
            dump_done_r  <= (state_nxt_s == DONE);
        end
    end

    assign data_a     = data_a_r;
    assign data_b     = data_b_r;
    assign dump_index = dump_index_r;
    assign dump_data  = dump_data_r;
    assign dump_valid = dump_valid_r;
    assign dump_busy  = dump_busy_r;
    assign dump_done  = dump_done_r;

endmodule

// File: tb/tb_regfile_dump.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump
//   Self-checking bench for regfile_dump. Two instances share the read/write
//   stimulus (WRITE_FIRST=1 and WRITE_FIRST=0); the dump sequencer is checked
//   on the WRITE_FIRST=1 instance against a queue of expected elements.
// -----------------------------------------------------------------------------
module tb_regfile_dump;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AW-1:0] read_addr_a;
    logic [AW-1:0] read_addr_b;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic          reg_write;
    logic          dump_start;
    logic          dump_ready;

    logic [DW-1:0] data_a, data_b, dump_data;
    logic [AW-1:0] dump_index;
    logic          dump_busy, dump_valid, dump_done;

    logic [DW-1:0] data_a0, data_b0, dump_data0;
    logic [AW-1:0] dump_index0;
    logic          dump_busy0, dump_valid0, dump_done0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model [DEPTH];

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] ea1;
        logic [DW-1:0] ea0;
        logic [DW-1:0] eb;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] a1;
        logic [DW-1:0] a0;
        logic [DW-1:0] b;
    } rexp_t;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } dexp_t;

    vec_t  vecs [10];
    rexp_t rq [$];
    dexp_t dq [$];

    always #5 clock = ~clock;

    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .WRITE_FIRST(1'b1)) u_wf1 (
        .clock(clock), .reset_n(reset_n),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .write_address(write_address), .write_data(write_data), .reg_write(reg_write),
        .data_a(data_a), .data_b(data_b),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_index(dump_index), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .WRITE_FIRST(1'b0)) u_wf0 (
        .clock(clock), .reset_n(reset_n),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .write_address(write_address), .write_data(write_data), .reg_write(reg_write),
        .data_a(data_a0), .data_b(data_b0),
        .dump_start(dump_start), .dump_busy(dump_busy0), .dump_valid(dump_valid0),
        .dump_ready(dump_ready), .dump_index(dump_index0), .dump_data(dump_data0),
        .dump_done(dump_done0)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
        end
    endtask

    // Drives the write port for the next edge and mirrors it in the model.
    task automatic drive_write(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        reg_write     = we;
        write_address = wa;
        write_data    = wd;
        if (we && (wa != '0)) begin
            model[wa] = wd;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " data_a"},     data_a,     '0);
        check({tag, " data_b"},     data_b,     '0);
        check({tag, " dump_index"}, DW'(dump_index), '0);
        check({tag, " dump_data"},  dump_data,  '0);
        check({tag, " dump_valid"}, DW'(dump_valid), '0);
        check({tag, " dump_busy"},  DW'(dump_busy),  '0);
        check({tag, " dump_done"},  DW'(dump_done),  '0);
    endtask

    // One dump from IDLE. stall_at: hold ready low 4 cycles at that index while
    // writing reg 6 = 99 then reg 7 = 77. abort_at: pulse reset at that index.
    // pulse_at: raise dump_start for one cycle at that index.
    task automatic run_dump(input int stall_at, input int abort_at, input int pulse_at, input string tag);
        int    cyc;
        int    stalls;
        int    busy_cnt;
        int    acc;
        int    ix;
        bit    fin;
        bit    aborted;
        dexp_t e;
        dq.delete();
        drive_write(1'b0, '0, '0);
        dump_ready = 1'b1;
        dump_start = 1'b1;
        e.idx  = '0;
        e.data = model[0];
        dq.push_back(e);
        @(negedge clock);
        cyc = 0; stalls = 0; busy_cnt = 0; acc = 0; fin = 1'b0; aborted = 1'b0;
        while (!fin && (cyc < 200)) begin
            cyc++;
            dump_start = 1'b0;
            drive_write(1'b0, '0, '0);
            if (dump_busy) begin
                busy_cnt++;
            end
            if (dump_done) begin
                fin = 1'b1;
                check({tag, " busy cycles"}, DW'(busy_cnt), DW'(DEPTH + stalls + 1));
                check({tag, " accepted"},    DW'(acc),      DW'(DEPTH));
                check({tag, " valid in done"}, DW'(dump_valid), '0);
            end else if (dump_valid) begin
                if (dq.size() == 0) begin
                    n_checks++;
                    $display("FAIL %s extra element: index %0d, none expected", tag, dump_index);
                    fin = 1'b1;
                end else begin
                    e  = dq[0];
                    ix = int'(dump_index);
                    check({tag, " index"}, DW'(dump_index), DW'(e.idx));
                    check({tag, " data"},  dump_data,       e.data);
                    if (ix == abort_at) begin
                        reset_n = 1'b0;
                        #1;
                        check_all_zero({tag, " async reset"});
                        aborted = 1'b1;
                        fin     = 1'b1;
                        clear_model();
                        dq.delete();
                        @(negedge clock);
                        check({tag, " no done after abort"}, DW'(dump_done), '0);
                        reset_n = 1'b1;
                    end else if ((ix == stall_at) && (stalls < 4)) begin
                        dump_ready = 1'b0;
                        if (stalls == 0) begin
                            drive_write(1'b1, 5'd6, 32'd99);
                        end else if (stalls == 1) begin
                            drive_write(1'b1, 5'd7, 32'd77);
                        end
                        stalls++;
                    end else begin
                        dump_ready = 1'b1;
                        if (ix == pulse_at) begin
                            dump_start = 1'b1;
                        end
                        void'(dq.pop_front());
                        acc++;
                        if (ix < DEPTH - 1) begin
                            e.idx  = AW'(ix + 1);
                            e.data = model[ix + 1];
                            dq.push_back(e);
                        end
                    end
                end
            end else begin
                n_checks++;
                $display("FAIL %s valid dropped: got valid=0 busy=%0d expected valid=1", tag, dump_busy);
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clock);
            end
        end
        if (!fin) begin
            n_checks++;
            $display("FAIL %s timeout: got no dump_done expected done within 200 cycles", tag);
        end
        dump_start = 1'b0;
        dump_ready = 1'b1;
        drive_write(1'b0, '0, '0);
        if (!aborted) begin
            @(negedge clock);
            check({tag, " busy after"},  DW'(dump_busy),  '0);
            check({tag, " done after"},  DW'(dump_done),  '0);
            check({tag, " valid after"}, DW'(dump_valid), '0);
        end
    endtask

    initial begin
        rexp_t r;
        reset_n       = 1'b0;
        read_addr_a   = '0;
        read_addr_b   = '0;
        write_address = '0;
        write_data    = '0;
        reg_write     = 1'b0;
        dump_start    = 1'b0;
        dump_ready    = 1'b1;
        clear_model();

        //          we    wa     wd            ra     rb     ea1           ea0           eb
        vecs[0] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd5,  32'hFFFFFFFB, 5'd1,  5'd2,  32'h0,        32'h0,        32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hFFFFFFFB, 32'hFFFFFFFB, 32'h0};
        vecs[3] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0,        32'h0,        32'hFFFFFFFB};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        vecs[5] = '{1'b1, 5'd3,  32'd15,       5'd3,  5'd5,  32'd15,       32'h0,        32'hFFFFFFFB};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'd15,       32'd15,       32'd15};
        vecs[7] = '{1'b1, 5'd1,  32'd10,       5'd1,  5'd3,  32'd10,       32'h0,        32'd15};
        vecs[8] = '{1'b1, 5'd15, 32'd5,        5'd15, 5'd1,  32'd5,        32'h0,        32'd10};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd15, 5'd1,  32'd5,        32'd5,        32'd10};

        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            drive_write(vecs[i].we, vecs[i].wa, vecs[i].wd);
            read_addr_a = vecs[i].ra;
            read_addr_b = vecs[i].rb;
            r.a1 = vecs[i].ea1;
            r.a0 = vecs[i].ea0;
            r.b  = vecs[i].eb;
            rq.push_back(r);
            @(negedge clock);
            r = rq.pop_front();
            check($sformatf("vec%0d data_a wf1", i), data_a,  r.a1);
            check($sformatf("vec%0d data_a wf0", i), data_a0, r.a0);
            check($sformatf("vec%0d data_b", i),     data_b,  r.b);
        end
        drive_write(1'b0, '0, '0);
        @(negedge clock);

        run_dump(-1, -1, -1, "free");
        run_dump(6, -1, -1, "backpressure");
        run_dump(-1, 10, -1, "abort");
        @(negedge clock);
        drive_write(1'b1, 5'd20, 32'hAB);
        @(negedge clock);
        drive_write(1'b0, '0, '0);
        run_dump(-1, -1, 12, "restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
